// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace serializer: FSM state enum, ASCII
// punctuation constants, record kind encoding and small BCD helpers.
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CARET,
    TIME,
    AT,
    PC,
    COLON,
    SP1,
    KIND,
    REG,
    ADDR,
    SP2,
    LT,
    EQ,
    SP3,
    DATA,
    HASH
  } state_t;

  localparam logic [7:0] CH_CARET  = 8'h5E;  // "^"
  localparam logic [7:0] CH_AT     = 8'h40;  // "@"
  localparam logic [7:0] CH_COLON  = 8'h3A;  // ":"
  localparam logic [7:0] CH_DOLLAR = 8'h24;  // "$"
  localparam logic [7:0] CH_STAR   = 8'h2A;  // "*"
  localparam logic [7:0] CH_LT     = 8'h3C;  // "<"
  localparam logic [7:0] CH_EQ     = 8'h3D;  // "="
  localparam logic [7:0] CH_HASH   = 8'h23;  // "#"
  localparam logic [7:0] CH_SPACE  = 8'h20;  // " "

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  // Index of the most significant non-zero BCD digit (0 when the value is 0,
  // so that a lone "0" is still printed).
  function automatic logic [1:0] bcd_msd(input logic [15:0] t);
    if (t[15:12] != 4'd0)      return 2'd3;
    else if (t[11:8] != 4'd0)  return 2'd2;
    else if (t[7:4] != 4'd0)   return 2'd1;
    else                       return 2'd0;
  endfunction

  // Decimal tens digit of a register number 0..31.
  function automatic logic [3:0] reg_tens(input logic [4:0] r);
    if (r >= 5'd30)      return 4'd3;
    else if (r >= 5'd20) return 4'd2;
    else if (r >= 5'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  // Decimal ones digit of a register number 0..31.
  function automatic logic [3:0] reg_ones(input logic [4:0] r);
    logic [4:0] rem;
    if (r >= 5'd30)      rem = r - 5'd30;
    else if (r >= 5'd20) rem = r - 5'd20;
    else if (r >= 5'd10) rem = r - 5'd10;
    else                 rem = r;
    return rem[3:0];
  endfunction

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to ASCII converter: 0-9 -> "0"-"9", 10-15 -> "a"-"f".
// Also used for BCD digits, which only ever take the 0-9 branch.
module hex_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Lowercase hex: "a" is 8'h61, so digits 10..15 are offset by 8'h57.
  assign ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                  : (8'h57 + {4'h0, nibble});

endmodule

// File: rtl/cpu_trace_serializer.sv
// Serializes CPU trace records (register or memory writes) into an ASCII
// character stream, one character per clock with no gaps.
// Optional build macro TRACE_COMPACT_EN: drop the three single spaces from
// each record for a denser stream.
module cpu_trace_serializer
  import cpu_trace_pkg::*;
#(
  parameter logic [7:0] IDLE_CHAR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [15:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  out_char,
  output logic        out_valid
);

`ifdef TRACE_COMPACT_EN
  localparam bit COMPACT = 1'b1;
`else
  localparam bit COMPACT = 1'b0;
`endif

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;

  logic        kind_reg;
  logic [15:0] time_reg;
  logic [31:0] pc_reg;
  logic [4:0]  reg_num_reg;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;

  logic        accept;
  logic [3:0]  nibble;
  logic [7:0]  digit_char;

  assign in_ready  = (state_reg == IDLE) || (state_reg == HASH);
  assign out_valid = (state_reg != IDLE);
  assign accept    = in_valid && in_ready;

  // State, digit counter and the record fields captured on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 3'd0;
      kind_reg    <= KIND_REG;
      time_reg    <= 16'd0;
      pc_reg      <= 32'd0;
      reg_num_reg <= 5'd0;
      addr_reg    <= 32'd0;
      data_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        kind_reg    <= in_kind;
        time_reg    <= in_time;
        pc_reg      <= in_pc;
        reg_num_reg <= in_reg;
        addr_reg    <= in_addr;
        data_reg    <= in_data;
      end
    end
  end

  // Next state; the counter is loaded with the index of the first digit of
  // each numeric field and counts down to 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = 3'd0;
        if (accept) state_next = CARET;
      end
      CARET: begin
        state_next = TIME;
        cnt_next   = {1'b0, bcd_msd(time_reg)};
      end
      TIME: begin
        if (cnt_reg == 3'd0) state_next = AT;
        else                 cnt_next   = cnt_reg - 3'd1;
      end
      AT: begin
        state_next = PC;
        cnt_next   = 3'd7;
      end
      PC: begin
        if (cnt_reg == 3'd0) state_next = COLON;
        else                 cnt_next   = cnt_reg - 3'd1;
      end
      COLON: state_next = COMPACT ? KIND : SP1;
      SP1:   state_next = KIND;
      KIND: begin
        if (kind_reg == KIND_MEM) begin
          state_next = ADDR;
          cnt_next   = 3'd7;
        end else begin
          state_next = REG;
          cnt_next   = (reg_num_reg >= 5'd10) ? 3'd1 : 3'd0;
        end
      end
      REG, ADDR: begin
        if (cnt_reg == 3'd0) state_next = COMPACT ? LT : SP2;
        else                 cnt_next   = cnt_reg - 3'd1;
      end
      SP2: state_next = LT;
      LT:  state_next = EQ;
      EQ: begin
        state_next = COMPACT ? DATA : SP3;
        cnt_next   = 3'd7;
      end
      SP3: begin
        state_next = DATA;
        cnt_next   = 3'd7;
      end
      DATA: begin
        if (cnt_reg == 3'd0) state_next = HASH;
        else                 cnt_next   = cnt_reg - 3'd1;
      end
      HASH: begin
        cnt_next   = 3'd0;
        state_next = accept ? CARET : IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // Select the nibble of the field currently being printed.
  always_comb begin
    nibble = 4'd0;
    case (state_reg)
      TIME: nibble = time_reg[{cnt_reg[1:0], 2'b00} +: 4];
      PC:   nibble = pc_reg[{cnt_reg, 2'b00} +: 4];
      ADDR: nibble = addr_reg[{cnt_reg, 2'b00} +: 4];
      DATA: nibble = data_reg[{cnt_reg, 2'b00} +: 4];
      REG:  nibble = cnt_reg[0] ? reg_tens(reg_num_reg) : reg_ones(reg_num_reg);
      default: nibble = 4'd0;
    endcase
  end

  hex_to_ascii u_hex_to_ascii (
    .nibble (nibble),
    .ascii  (digit_char)
  );

  // Character produced for the current state.
  always_comb begin
    out_char = IDLE_CHAR;
    case (state_reg)
      CARET:                   out_char = CH_CARET;
      TIME, PC, REG, ADDR, DATA: out_char = digit_char;
      AT:                      out_char = CH_AT;
      COLON:                   out_char = CH_COLON;
      SP1, SP2, SP3:           out_char = CH_SPACE;
      KIND:                    out_char = (kind_reg == KIND_MEM) ? CH_STAR : CH_DOLLAR;
      LT:                      out_char = CH_LT;
      EQ:                      out_char = CH_EQ;
      HASH:                    out_char = CH_HASH;
      default:                 out_char = IDLE_CHAR;
    endcase
  end

endmodule

// File: tb/tb_cpu_trace_serializer.sv
// Self-checking bench for cpu_trace_serializer: directed and random records
// compared character by character against strings formatted from the record
// fields.
module tb_cpu_trace_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_kind;
  logic [15:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_reg;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [7:0]  out_char;
  logic        out_valid;

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit          kind;
    logic [15:0] t;
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  cpu_trace_serializer #(.IDLE_CHAR(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_time   (in_time),
    .in_pc     (in_pc),
    .in_reg    (in_reg),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .out_char  (out_char),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Expected record text; BCD time printed as hex with no padding gives the
  // decimal digits with leading zeros suppressed.
  function automatic string make_text(rec_t r);
`ifdef TRACE_COMPACT_EN
    if (r.kind) return $sformatf("^%0h@%08h:*%08h<=%08h#", r.t, r.pc, r.addr, r.data);
    else        return $sformatf("^%0h@%08h:$%0d<=%08h#", r.t, r.pc, r.rg, r.data);
`else
    if (r.kind) return $sformatf("^%0h@%08h: *%08h <= %08h#", r.t, r.pc, r.addr, r.data);
    else        return $sformatf("^%0h@%08h: $%0d <= %08h#", r.t, r.pc, r.rg, r.data);
`endif
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    int   lz;
    r.kind = 1'($urandom_range(0, 1));
    for (int d = 0; d < 4; d++) r.t[d*4 +: 4] = 4'($urandom_range(0, 9));
    lz = $urandom_range(0, 4);
    for (int d = 0; d < 4; d++) if (d >= 4 - lz) r.t[d*4 +: 4] = 4'd0;
    r.pc   = $urandom;
    r.rg   = 5'($urandom_range(0, 31));
    r.addr = $urandom;
    r.data = $urandom;
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic drive(rec_t r, bit v);
    in_valid = v;
    in_kind  = r.kind;
    in_time  = r.t;
    in_pc    = r.pc;
    in_reg   = r.rg;
    in_addr  = r.addr;
    in_data  = r.data;
  endtask

  // Offer a record from a cycle where in_ready is high; it is accepted on the
  // next edge. With hold set, in_valid stays high afterwards.
  task automatic send(rec_t r, bit hold);
    drive(r, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  // Check the first n characters of a record, one per cycle, no gaps.
  task automatic expect_stream(string tag, string s, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_char"}, 32'(out_char), 32'(s[i]));
      check({tag, "_ready"}, 32'(in_ready), (i == s.len() - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_idle(string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_char"}, 32'(out_char), 32'h00);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  rec_t  dir[5];
  rec_t  ra, rb, r;
  string s;
  bit    b2b;

  initial begin
    reset = 1'b1;
    drive('{1'b0, 16'h0, 32'h0, 5'd0, 32'h0, 32'h0}, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    dir[0] = '{1'b0, 16'h0012, 32'h00003000, 5'd5,  32'h0,        32'h0000abcd};
    dir[1] = '{1'b1, 16'h0000, 32'h00003004, 5'd0,  32'h00000010, 32'hffffffff};
    dir[2] = '{1'b0, 16'h9999, 32'h12345678, 5'd31, 32'h0,        32'h9abcdef0};
    dir[3] = '{1'b0, 16'h0100, 32'hdeadbeef, 5'd10, 32'h0,        32'h00000001};
    dir[4] = '{1'b0, 16'h0007, 32'h00000000, 5'd0,  32'h0,        32'h80000000};

    foreach (dir[k]) begin
      s = make_text(dir[k]);
      $display("directed %0d: %s", k, s);
      send(dir[k], 1'b0);
      expect_stream($sformatf("dir%0d", k), s, s.len());
      @(negedge clk);
      check_idle($sformatf("dir%0d_after", k));
    end

    // Back-to-back with in_valid held high across both records.
    ra = dir[0];
    rb = dir[1];
    $display("back_to_back: %s %s", make_text(ra), make_text(rb));
    send(ra, 1'b1);
    expect_stream("b2b_a", make_text(ra), make_text(ra).len());
    drive(rb, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_stream("b2b_b", make_text(rb), make_text(rb).len());
    @(negedge clk);
    check_idle("b2b_after");

    // Reset on the 10th character aborts the record; in_valid ignored in reset.
    s = make_text(dir[2]);
    $display("reset_abort: %s", s);
    send(dir[2], 1'b0);
    expect_stream("abort", s, 10);
    reset = 1'b1;
    drive(dir[0], 1'b1);
    @(negedge clk);
    check_idle("abort_reset1");
    @(negedge clk);
    check_idle("abort_reset2");
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("abort_released");
    s = make_text(dir[0]);
    send(dir[0], 1'b0);
    expect_stream("after_abort", s, s.len());
    @(negedge clk);
    check_idle("after_abort_idle");

    // Random records, randomly chained back-to-back or separated by gaps.
    r = rand_rec();
    send(r, 1'b0);
    for (int k = 0; k < 20; k++) begin
      s = make_text(r);
      $display("random %0d: %s", k, s);
      expect_stream($sformatf("rnd%0d", k), s, s.len());
      b2b = 1'($urandom_range(0, 1));
      if (k < 19 && b2b) begin
        r = rand_rec();
        send(r, 1'b0);
      end else begin
        @(negedge clk);
        check_idle($sformatf("rnd%0d_idle", k));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (k < 19) begin
          r = rand_rec();
          send(r, 1'b0);
        end
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
